// File: rtl/mem_access_pkg.sv
// Shared types for the pixel-memory access arbiter.
// Memory command encoding, FSM states and grant history.
package mem_access_pkg;

  typedef enum logic [1:0] {
    INSTR_NONE  = 2'b00,
    INSTR_READ  = 2'b01,
    INSTR_WRITE = 2'b10
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR_ISSUE
  } state_t;

  typedef enum logic {
    GRANT_RD,
    GRANT_WR
  } grant_t;

endpackage

// File: rtl/mem_req_slot.sv
// Single-entry request holder: valid bit plus payload.
// A capture is dropped while the slot is already occupied.
module mem_req_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         capture_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (capture_i && !valid_q) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mem_access_arbiter.sv
// Fair read/write arbiter in front of a single-port pixel memory.
// Issues one-cycle commands, stalls on busy, returns read data.
module mem_access_arbiter
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start_read,
  input  logic [ADDR_W-1:0] addr_r_mc,
  input  logic              start_write,
  input  logic [ADDR_W-1:0] addr_w_mc,
  input  logic [DATA_W-1:0] data_w,
  input  logic              busy,
  input  logic [DATA_W-1:0] data_r,
  output logic [1:0]        instruction,
  output logic [ADDR_W-1:0] addr_r,
  output logic [ADDR_W-1:0] addr_w,
  output logic [DATA_W-1:0] data_w_o,
  output logic [DATA_W-1:0] data_r_o,
  output logic              read_data_done,
  output logic              write_done,
  output logic              rd_pending,
  output logic              wr_pending
);

  localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  state_t             state_q, state_d;
  grant_t             last_q, last_d;
  logic [CNT_W-1:0]   lat_q, lat_d;
  logic [DATA_W-1:0]  dro_q, dro_d;
  logic               rdd_q, rdd_d;
  logic               wrd_q, wrd_d;
  instr_t             instr_d;

  logic               rd_v, wr_v;
  logic               rd_clr, wr_clr;
  logic [ADDR_W-1:0]  rd_addr, wr_addr;
  logic [DATA_W-1:0]  wr_data;

  mem_req_slot #(.W(ADDR_W)) u_rd_slot (
    .clk      (clk),
    .n_rst    (n_rst),
    .capture_i(start_read),
    .clear_i  (rd_clr),
    .data_i   (addr_r_mc),
    .valid_o  (rd_v),
    .data_o   (rd_addr)
  );

  mem_req_slot #(.W(ADDR_W + DATA_W)) u_wr_slot (
    .clk      (clk),
    .n_rst    (n_rst),
    .capture_i(start_write),
    .clear_i  (wr_clr),
    .data_i   ({addr_w_mc, data_w}),
    .valid_o  (wr_v),
    .data_o   ({wr_addr, wr_data})
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    lat_d    = lat_q;
    dro_d    = dro_q;
    rdd_d    = 1'b0;
    wrd_d    = 1'b0;
    rd_clr   = 1'b0;
    wr_clr   = 1'b0;
    instr_d  = INSTR_NONE;
    addr_r   = '0;
    addr_w   = '0;
    data_w_o = '0;
    unique case (state_q)
      ST_IDLE: begin
        // Only contended grants update the fairness history
        if (rd_v && wr_v) begin
          if (last_q == GRANT_WR) begin
            state_d = ST_RD_ISSUE;
            last_d  = GRANT_RD;
          end else begin
            state_d = ST_WR_ISSUE;
            last_d  = GRANT_WR;
          end
        end else if (rd_v) begin
          state_d = ST_RD_ISSUE;
        end else if (wr_v) begin
          state_d = ST_WR_ISSUE;
        end
      end
      ST_RD_ISSUE: begin
        if (!busy) begin
          instr_d = INSTR_READ;
          addr_r  = rd_addr;
          state_d = ST_RD_WAIT;
          lat_d   = CNT_W'(RD_LAT);
        end
      end
      ST_RD_WAIT: begin
        if (lat_q == CNT_W'(1)) begin
          dro_d   = data_r;
          rdd_d   = 1'b1;
          rd_clr  = 1'b1;
          lat_d   = '0;
          state_d = ST_IDLE;
        end else begin
          lat_d = lat_q - CNT_W'(1);
        end
      end
      ST_WR_ISSUE: begin
        if (!busy) begin
          instr_d  = INSTR_WRITE;
          addr_w   = wr_addr;
          data_w_o = wr_data;
          wrd_d    = 1'b1;
          wr_clr   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      last_q  <= GRANT_WR;
      lat_q   <= '0;
      dro_q   <= '0;
      rdd_q   <= 1'b0;
      wrd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      lat_q   <= lat_d;
      dro_q   <= dro_d;
      rdd_q   <= rdd_d;
      wrd_q   <= wrd_d;
    end
  end

  assign instruction    = instr_d;
  assign data_r_o       = dro_q;
  assign read_data_done = rdd_q;
  assign write_done     = wrd_q;
  assign rd_pending     = rd_v;
  assign wr_pending     = wr_v;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: two instances (RD_LAT 1 and 3)
// driven in lockstep and compared with a transaction-level model.
module tb_mem_access_arbiter;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start_read = 1'b0;
  logic [7:0] addr_r_mc = '0;
  logic       start_write = 1'b0;
  logic [7:0] addr_w_mc = '0;
  logic [7:0] data_w = '0;
  logic       busy = 1'b0;

  logic [7:0] data_r [2];
  logic [1:0] instruction [2];
  logic [7:0] addr_r [2];
  logic [7:0] addr_w [2];
  logic [7:0] data_w_o [2];
  logic [7:0] data_r_o [2];
  logic       read_data_done [2];
  logic       write_done [2];
  logic       rd_pending [2];
  logic       wr_pending [2];

  int nchk = 0;
  int nerr = 0;

  logic [7:0] mem [256];

  // cur: 0 = no access, 1 = read awaiting issue,
  //      2 = read in flight, 3 = write awaiting issue
  typedef struct {
    bit         rv;
    logic [7:0] ra;
    bit         wv;
    logic [7:0] wa;
    logic [7:0] wd;
    bit         last_wr;
    int         cur;
    int         left;
    logic [7:0] dro;
    bit         rdd;
    bit         wrd;
  } mdl_t;

  mdl_t m [2];

  always #5 clk = ~clk;

  mem_access_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_dut0 (
    .clk           (clk),
    .n_rst         (n_rst),
    .start_read    (start_read),
    .addr_r_mc     (addr_r_mc),
    .start_write   (start_write),
    .addr_w_mc     (addr_w_mc),
    .data_w        (data_w),
    .busy          (busy),
    .data_r        (data_r[0]),
    .instruction   (instruction[0]),
    .addr_r        (addr_r[0]),
    .addr_w        (addr_w[0]),
    .data_w_o      (data_w_o[0]),
    .data_r_o      (data_r_o[0]),
    .read_data_done(read_data_done[0]),
    .write_done    (write_done[0]),
    .rd_pending    (rd_pending[0]),
    .wr_pending    (wr_pending[0])
  );

  mem_access_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) u_dut1 (
    .clk           (clk),
    .n_rst         (n_rst),
    .start_read    (start_read),
    .addr_r_mc     (addr_r_mc),
    .start_write   (start_write),
    .addr_w_mc     (addr_w_mc),
    .data_w        (data_w),
    .busy          (busy),
    .data_r        (data_r[1]),
    .instruction   (instruction[1]),
    .addr_r        (addr_r[1]),
    .addr_w        (addr_w[1]),
    .data_w_o      (data_w_o[1]),
    .data_r_o      (data_r_o[1]),
    .read_data_done(read_data_done[1]),
    .write_done    (write_done[1]),
    .rd_pending    (rd_pending[1]),
    .wr_pending    (wr_pending[1])
  );

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic mdl_t mreset();
    mdl_t n;
    n.rv = 0; n.ra = '0; n.wv = 0; n.wa = '0; n.wd = '0;
    n.last_wr = 1; n.cur = 0; n.left = 0; n.dro = '0;
    n.rdd = 0; n.wrd = 0;
    return n;
  endfunction

  function automatic mdl_t step(mdl_t mi, int lat, bit sr,
                                logic [7:0] ar, bit sw,
                                logic [7:0] aw, logic [7:0] dw,
                                bit bz, logic [7:0] drv);
    mdl_t n = mi;
    bit cap_r = sr && !mi.rv;
    bit cap_w = sw && !mi.wv;
    n.rdd = 0;
    n.wrd = 0;
    case (mi.cur)
      0: begin
        if (mi.rv && mi.wv) begin
          n.cur = mi.last_wr ? 1 : 3;
          n.last_wr = !mi.last_wr;
        end else if (mi.rv) n.cur = 1;
        else if (mi.wv) n.cur = 3;
      end
      1: if (!bz) begin n.cur = 2; n.left = lat; end
      2: begin
        if (mi.left == 1) begin
          n.dro = drv; n.rv = 0; n.rdd = 1; n.cur = 0;
        end else n.left = mi.left - 1;
      end
      3: if (!bz) begin n.wv = 0; n.wrd = 1; n.cur = 0; end
      default: n.cur = 0;
    endcase
    if (cap_r) begin n.rv = 1; n.ra = ar; end
    if (cap_w) begin n.wv = 1; n.wa = aw; n.wd = dw; end
    return n;
  endfunction

  task automatic chk(string tag, int i, logic [7:0] obs,
                     logic [7:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s[lat%0d] got %0h want %0h",
             tag, lat_of(i), obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      bit iss_r = n_rst && m[i].cur == 1 && !busy;
      bit iss_w = n_rst && m[i].cur == 3 && !busy;
      logic [7:0] ei = iss_r ? 8'd1 : (iss_w ? 8'd2 : 8'd0);
      chk("instruction", i, 8'(instruction[i]), ei);
      chk("addr_r", i, addr_r[i], iss_r ? m[i].ra : 8'd0);
      chk("addr_w", i, addr_w[i], iss_w ? m[i].wa : 8'd0);
      chk("data_w_o", i, data_w_o[i], iss_w ? m[i].wd : 8'd0);
      chk("data_r_o", i, data_r_o[i], m[i].dro);
      chk("read_data_done", i, 8'(read_data_done[i]), 8'(m[i].rdd));
      chk("write_done", i, 8'(write_done[i]), 8'(m[i].wrd));
      chk("rd_pending", i, 8'(rd_pending[i]), 8'(m[i].rv));
      chk("wr_pending", i, 8'(wr_pending[i]), 8'(m[i].wv));
    end
  endtask

  // Entered just after a negedge; leaves just after the next one.
  task automatic cyc(bit sr, logic [7:0] ar, bit sw,
                     logic [7:0] aw, logic [7:0] dw, bit bz);
    start_read = sr; addr_r_mc = ar;
    start_write = sw; addr_w_mc = aw; data_w = dw;
    busy = bz;
    for (int i = 0; i < 2; i++)
      data_r[i] = (m[i].cur == 2 && m[i].left == 1) ?
                  mem[m[i].ra] : ~mem[m[i].ra];
    #1;
    check_all();
    @(posedge clk);
    for (int i = 0; i < 2; i++)
      m[i] = step(m[i], lat_of(i), sr, ar, sw, aw, dw, bz, data_r[i]);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(0, 8'h00, 0, 8'h00, 8'h00, 0);
  endtask

  task automatic rst();
    n_rst = 1'b0;
    start_read = 0; start_write = 0; busy = 0;
    for (int i = 0; i < 2; i++) m[i] = mreset();
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    #1;
    check_all();
    n_rst = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    mem[8'h2A] = 8'h5C;
    mem[8'h44] = 8'h91;
    data_r[0] = '0;
    data_r[1] = '0;
    for (int i = 0; i < 2; i++) m[i] = mreset();
    @(negedge clk);

    rst();
    cyc(1, 8'h2A, 0, 8'h00, 8'h00, 0);
    idle(6);

    cyc(0, 8'h00, 1, 8'h10, 8'hFF, 0);
    cyc(0, 8'h00, 0, 8'h00, 8'h00, 1);
    cyc(0, 8'h00, 0, 8'h00, 8'h00, 1);
    cyc(0, 8'h00, 0, 8'h00, 8'h00, 1);
    idle(3);

    rst();
    cyc(1, 8'h2A, 1, 8'h20, 8'hC3, 0);
    idle(9);
    cyc(1, 8'h07, 1, 8'h21, 8'h3C, 0);
    idle(9);

    cyc(1, 8'h44, 0, 8'h00, 8'h00, 0);
    cyc(1, 8'h33, 0, 8'h00, 8'h00, 1);
    idle(7);

    cyc(1, 8'h2A, 0, 8'h00, 8'h00, 0);
    for (int t = 0; t < 10 && m[1].cur != 2; t++) idle(1);
    idle(1);
    rst();
    idle(6);

    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 149) == 0) rst();
      else cyc(bit'($urandom_range(0, 2) == 0), 8'($urandom),
               bit'($urandom_range(0, 2) == 0), 8'($urandom),
               8'($urandom), bit'($urandom_range(0, 3) == 0));
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
